pipe_elastic_chain: RTL and testbench
=====================================

// Module: pipe_elastic_chain
// PURPOSE
//  Parametrised elastic pipeline: DEPTH register stages of WIDTH bits, each with its own valid bit.
//  Uses a valid/ready handshake plus a global synchronous flush.
//  Successor to the single-stage stall/flush pipe register.
//  Bubbles collapse: a stage accepts new data whenever it is empty, even if later stages stall.
//  Used between CPU pipeline stages and in multi-cycle datapaths (e.g. MUL/DIV staging).
// PARAMETERS
//  WIDTH  32  payload width in bits (>=1)
//  DEPTH  2   number of register stages (>=1)
// PORTS
//  clk_i        in   1      clock, all state updates on rising edge
//  rst_i        in   1      asynchronous reset, active low
//  flush_i      in   1      synchronous flush, kills all in-flight entries
//  in_valid_i   in   1      upstream has data on in_data_i
//  in_data_i    in   WIDTH  upstream payload
//  in_ready_o   out  1      chain can accept in_data_i this cycle
//  out_valid_o  out  1      out_data_o holds a valid entry
//  out_data_o   out  WIDTH  payload of last stage
//  out_ready_i  in   1      downstream accepts out_data_o this cycle
//  occ_o        out  $clog2(DEPTH+1)  number of valid stages (only with PIPE_OCC_EN)
// BEHAVIOUR
//  - State per stage k (0..DEPTH-1): vld[k], dat[k]. Stage 0 is the input end, stage DEPTH-1 the output end.
//  - Reset (rst_i=0, async): all vld=0, all dat=0.
//    Outputs during reset: out_valid_o=0, out_data_o=0, in_ready_o=1, occ_o=0.
//  - Ready chain (combinational):
//    - rdy[DEPTH] = out_ready_i.
//    - rdy[k] = ~vld[k] | rdy[k+1].
//    - in_ready_o = rdy[0] & ~flush_i.
//  - Transfers:
//    - Input: in_valid_i & in_ready_o.
//    - Stage k-1 -> k: vld[k-1] & rdy[k].
//    - Output: out_valid_o & out_ready_i.
//  - Stage update, no flush. On each edge, stage k:
//    - Loads if its source is valid and rdy[k]=1: dat[k] <= source data, vld[k] <= 1.
//    - Otherwise, if rdy[k+1]=1: vld[k] <= 0.
//    - Otherwise: holds.
//  - dat[k] changes only on a load. Empty stages keep stale data.
//  - Simultaneous load and drain of the same stage: the load wins (vld stays 1).
//  - Latency: DEPTH cycles from input transfer to out_valid_o with no stalls.
//  - Throughput: 1 entry/cycle sustained while out_ready_i=1.
//  - Ordering: entries leave strictly in arrival order. No drop and no duplication except by flush.
//  - Full: all vld=1 and out_ready_i=0 -> in_ready_o=0 and every stage holds.
//  - Full with out_ready_i=1: the output drains and the input is accepted in the same cycle (no bubble).
//  - flush_i=1:
//    - On the next edge, all vld <= 0 and dat is unchanged.
//    - in_ready_o=0 and out_valid_o=0 during the flush cycle, so no transfer can occur that cycle.
//    - out_valid_o = vld[DEPTH-1] & ~flush_i.
//  - Reset mid-operation: all state is cleared immediately. Entries in flight are lost.
//  - DEPTH=1: a single register with in_ready_o = ~vld[0] | out_ready_i.
//  - out_data_o = dat[DEPTH-1], registered. There is no combinational path from in_data_i to outputs.
// CONFIGURATION
//  - PIPE_OCC_EN defined:
//    - Port occ_o exists and equals the popcount of vld[]. It is combinational from the registers.
//    - occ_o=0 on reset and 0 in the cycle after a flush.
//  - PIPE_OCC_EN undefined: occ_o port and the popcount logic are absent. All other behaviour is identical.
// TESTING
//  1. Reset, DEPTH=3, WIDTH=8, out_ready_i=1; stream 0x01..0x05 on consecutive cycles.
//     -> 0x01 at output 3 cycles after acceptance, then 0x02..0x05 back-to-back; in_ready_o stays 1.
//  2. out_ready_i=0, push 4 entries into DEPTH=3.
//     -> 3 accepted, then in_ready_o=0 and occ_o=3; raise out_ready_i -> 0x01 out and 4th accepted same cycle.
//  3. Bubble collapse: fill stage 2 only, hold out_ready_i=0, push 2 entries.
//     -> both accepted (occ_o 1->3), then in_ready_o=0.
//  4. Full chain holding 0xA1..0xA3, assert flush_i one cycle with in_valid_i=1.
//     -> out_valid_o=0 and in_ready_o=0 that cycle; next cycle occ_o=0 and the input was dropped.
//  5. Assert rst_i=0 asynchronously mid-stream, between edges.
//     -> out_valid_o=0, out_data_o=0, in_ready_o=1 immediately.
//  6. Random in_valid_i/out_ready_i for 10k cycles, DEPTH=1 and DEPTH=4.
//     -> output sequence equals input sequence; occ_o equals scoreboard count.

Source files
------------

// File: rtl/pipe_elastic_chain.sv
// pipe_elastic_chain
//   Elastic pipeline of DEPTH register stages, WIDTH bits each, with a
//   per-stage valid bit, valid/ready handshake and a global synchronous flush.
//   An empty stage always accepts new data, so bubbles collapse even while
//   later stages are stalled. Output data is taken straight from the last
//   stage register, so there is no combinational path from in_data_i.
//
//   Parameters: WIDTH (payload bits, >=1), DEPTH (stages, >=1)
//   Ports:
//     clk_i        clock, rising edge
//     rst_i        asynchronous reset, active low
//     flush_i      synchronous flush, clears every valid bit on the next edge
//     in_valid_i   upstream payload valid
//     in_data_i    upstream payload
//     in_ready_o   chain accepts in_data_i this cycle
//     out_valid_o  out_data_o holds a valid entry
//     out_data_o   payload of the last stage
//     out_ready_i  downstream accepts out_data_o this cycle
//     occ_o        number of valid stages (only when PIPE_OCC_EN is defined)
//   Build option: define PIPE_OCC_EN to add the occ_o occupancy port.

module pipe_elastic_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  output logic [WIDTH-1:0]           out_data_o,
  input  logic                       out_ready_i
`ifdef PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ_o
`endif
);

  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat     [DEPTH];
  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] src_vld;
  logic [WIDTH-1:0] src_dat [DEPTH];

  // rdy[k]: stage k can take data, either because it is empty or because its
  // occupant moves on this edge. A running variable keeps the chain acyclic.
  always_comb begin
    logic r;
    r          = out_ready_i;
    rdy        = '0;
    rdy[DEPTH] = out_ready_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      r      = ~vld[k] | r;
      rdy[k] = r;
    end
  end

  // Each stage's source: the input port for stage 0, the previous stage otherwise.
  always_comb begin
    src_vld    = '0;
    src_vld[0] = in_valid_i;
    src_dat[0] = in_data_i;
    for (int k = 1; k < DEPTH; k++) begin
      src_vld[k] = vld[k-1];
      src_dat[k] = dat[k-1];
    end
  end

  // A load takes priority over a drain, so a stage that passes its entry on
  // and receives a new one in the same edge stays valid.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dat[k] <= '0;
      end
    end else if (flush_i) begin
      vld <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (src_vld[k] && rdy[k]) begin
          vld[k] <= 1'b1;
          dat[k] <= src_dat[k];
        end else if (rdy[k+1]) begin
          vld[k] <= 1'b0;
        end
      end
    end
  end

  // Flush masks both handshakes so nothing transfers in the flush cycle.
  assign in_ready_o  = rdy[0] & ~flush_i;
  assign out_valid_o = vld[DEPTH-1] & ~flush_i;
  assign out_data_o  = dat[DEPTH-1];

`ifdef PIPE_OCC_EN
  assign occ_o = $bits(occ_o)'($countones(vld));
`endif

endmodule

// File: tb/tb_pipe_elastic_chain.sv
// tb_pipe_elastic_chain
//   Three chains (DEPTH 3, 1, 4; WIDTH 8) share clock and reset. Instance 0
//   gets directed sequences with literal expectations; instances 1 and 2 get
//   random traffic. A slot-occupancy model plus an in-order scoreboard per
//   instance is compared with the DUT on every falling edge.

module tb_pipe_elastic_chain;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       iv0 = 0, iv1 = 0, iv2 = 0;
  logic [7:0] id0 = 0, id1 = 0, id2 = 0;
  logic       or0 = 0, or1 = 0, or2 = 0;
  logic       fl0 = 0, fl1 = 0, fl2 = 0;
  logic       ir0, ir1, ir2;
  logic       ov0, ov1, ov2;
  logic [7:0] od0, od1, od2;
`ifdef PIPE_OCC_EN
  logic [1:0] oc0;
  logic [0:0] oc1;
  logic [2:0] oc2;
`endif

  pipe_elastic_chain #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(fl0), .in_valid_i(iv0), .in_data_i(id0),
    .in_ready_o(ir0), .out_valid_o(ov0), .out_data_o(od0), .out_ready_i(or0)
`ifdef PIPE_OCC_EN
    , .occ_o(oc0)
`endif
  );
  pipe_elastic_chain #(.WIDTH(8), .DEPTH(1)) u_d1 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(fl1), .in_valid_i(iv1), .in_data_i(id1),
    .in_ready_o(ir1), .out_valid_o(ov1), .out_data_o(od1), .out_ready_i(or1)
`ifdef PIPE_OCC_EN
    , .occ_o(oc1)
`endif
  );
  pipe_elastic_chain #(.WIDTH(8), .DEPTH(4)) u_d4 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(fl2), .in_valid_i(iv2), .in_data_i(id2),
    .in_ready_o(ir2), .out_valid_o(ov2), .out_data_o(od2), .out_ready_i(or2)
`ifdef PIPE_OCC_EN
    , .occ_o(oc2)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int depth_of(input int i);
    case (i) 0: return 3; 1: return 1; default: return 4; endcase
  endfunction
  function automatic logic in_v(input int i);
    case (i) 0: return iv0; 1: return iv1; default: return iv2; endcase
  endfunction
  function automatic logic [7:0] in_d(input int i);
    case (i) 0: return id0; 1: return id1; default: return id2; endcase
  endfunction
  function automatic logic o_r(input int i);
    case (i) 0: return or0; 1: return or1; default: return or2; endcase
  endfunction
  function automatic logic flu(input int i);
    case (i) 0: return fl0; 1: return fl1; default: return fl2; endcase
  endfunction
  function automatic logic d_ir(input int i);
    case (i) 0: return ir0; 1: return ir1; default: return ir2; endcase
  endfunction
  function automatic logic d_ov(input int i);
    case (i) 0: return ov0; 1: return ov1; default: return ov2; endcase
  endfunction
  function automatic logic [7:0] d_od(input int i);
    case (i) 0: return od0; 1: return od1; default: return od2; endcase
  endfunction
`ifdef PIPE_OCC_EN
  function automatic logic [31:0] d_oc(input int i);
    case (i) 0: return 32'(oc0); 1: return 32'(oc1); default: return 32'(oc2); endcase
  endfunction
`endif

  // Model: slot p of instance i holds an entry or not. An entry leaves the
  // last slot when downstream is ready, and an entry advances whenever the
  // slot ahead is empty or being vacated.
  logic       m_vld [3][4];
  logic [7:0] m_dat [3][4];
  logic [7:0] sb    [3][16];
  int         sb_wr [3];
  int         sb_rd [3];

  function automatic logic [3:0] moves(input int i, input logic ordy);
    logic [3:0] m;
    logic       ahead_free;
    int         d;
    d = depth_of(i);
    m = '0;
    for (int p = d - 1; p >= 0; p--) begin
      if (p == d - 1) ahead_free = ordy;
      else            ahead_free = !m_vld[i][p+1] || m[p+1];
      m[p] = m_vld[i][p] && ahead_free;
    end
    return m;
  endfunction

  function automatic int model_count(input int i);
    int n = 0;
    for (int p = 0; p < depth_of(i); p++) if (m_vld[i][p]) n++;
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < 4; p++) begin
        m_vld[i][p] = 1'b0;
        m_dat[i][p] = 8'h00;
      end
      sb_wr[i] = 0;
      sb_rd[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    logic [3:0] mv;
    logic       acc;
    int         d;
    d  = depth_of(i);
    mv = moves(i, o_r(i));
    if (flu(i)) begin
      for (int p = 0; p < 4; p++) m_vld[i][p] = 1'b0;
      sb_rd[i] = sb_wr[i];
    end else begin
      acc = in_v(i) && (!m_vld[i][0] || mv[0]);
      for (int p = d - 1; p >= 1; p--) begin
        if (mv[p-1]) begin
          m_vld[i][p] = 1'b1;
          m_dat[i][p] = m_dat[i][p-1];
        end else if (mv[p]) begin
          m_vld[i][p] = 1'b0;
        end
      end
      if (acc) begin
        m_vld[i][0] = 1'b1;
        m_dat[i][0] = in_d(i);
        sb[i][sb_wr[i] % 16] = in_d(i);
        sb_wr[i]++;
      end else if (mv[0]) begin
        m_vld[i][0] = 1'b0;
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk_i or negedge rst_i);
      if (!rst_i) model_clear();
      else for (int i = 0; i < 3; i++) model_step(i);
    end
  end

  // Compare process: every falling edge, all instances.
  initial begin
    forever begin
      @(negedge clk_i);
      for (int i = 0; i < 3; i++) begin
        int         d;
        logic [3:0] mv;
        d  = depth_of(i);
        mv = moves(i, o_r(i));
        check($sformatf("i%0d_in_ready", i), 32'(d_ir(i)),
              32'((!m_vld[i][0] || mv[0]) && !flu(i)));
        check($sformatf("i%0d_out_valid", i), 32'(d_ov(i)), 32'(m_vld[i][d-1] && !flu(i)));
        check($sformatf("i%0d_out_data", i), 32'(d_od(i)), 32'(m_dat[i][d-1]));
`ifdef PIPE_OCC_EN
        check($sformatf("i%0d_occ", i), d_oc(i), 32'(model_count(i)));
`endif
        if (d_ov(i) && o_r(i)) begin
          if (sb_rd[i] == sb_wr[i]) begin
            check($sformatf("i%0d_sb_underflow", i), 32'(d_od(i)), 32'hFFFF_FFFF);
          end else begin
            check($sformatf("i%0d_sb_order", i), 32'(d_od(i)), 32'(sb[i][sb_rd[i] % 16]));
            sb_rd[i]++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Random traffic on the DEPTH=1 and DEPTH=4 chains.
  logic rand_done = 1'b0;
  initial begin
    wait (rst_i === 1'b1);
    for (int n = 0; n < 10000; n++) begin
      step();
      iv1 = ($urandom_range(0, 3) != 0);
      id1 = 8'($urandom_range(0, 255));
      or1 = ($urandom_range(0, 2) != 0);
      fl1 = ($urandom_range(0, 59) == 0);
      iv2 = ($urandom_range(0, 1) != 0);
      id2 = 8'($urandom_range(0, 255));
      or2 = ($urandom_range(0, 3) != 0);
      fl2 = ($urandom_range(0, 59) == 0);
    end
    step();
    iv1 = 0; fl1 = 0; or1 = 1;
    iv2 = 0; fl2 = 0; or2 = 1;
    rand_done = 1'b1;
  end

  initial begin
    #1;
    check("reset_out_valid", 32'(ov0), 32'h0);
    check("reset_out_data", 32'(od0), 32'h0);
    check("reset_in_ready", 32'(ir0), 32'h1);
    #12 rst_i = 1'b1;

    // 1: stream 0x01..0x05, three-cycle latency, back-to-back output
    step(); or0 = 1; iv0 = 1; id0 = 8'h01;
    for (int d = 2; d <= 5; d++) begin
      step();
      id0 = 8'(d);
      check("t1_in_ready", 32'(ir0), 32'h1);
      if (d >= 4) check("t1_out_data", 32'(od0), 32'(d - 3));
      else        check("t1_no_out_yet", 32'(ov0), 32'h0);
    end
    step(); iv0 = 0;
    check("t1_out3", 32'(od0), 32'h03);
    step(); check("t1_out4", 32'(od0), 32'h04);
    step(); check("t1_out5", 32'(od0), 32'h05);
    check("t1_out5_valid", 32'(ov0), 32'h1);
    step(); check("t1_drained", 32'(ov0), 32'h0);

    // 2: stall with four pushes, release
    or0 = 0; iv0 = 1; id0 = 8'h01;
    step(); id0 = 8'h02;
    step(); id0 = 8'h03;
    step(); id0 = 8'h04;
    check("t2_full_ready", 32'(ir0), 32'h0);
    check("t2_full_out", 32'(od0), 32'h01);
`ifdef PIPE_OCC_EN
    check("t2_occ3", 32'(oc0), 32'h3);
`endif
    step(); check("t2_hold", 32'(od0), 32'h01);
    or0 = 1; #1;
    check("t2_release_ready", 32'(ir0), 32'h1);
    step(); iv0 = 0;
    check("t2_next_out", 32'(od0), 32'h02);
`ifdef PIPE_OCC_EN
    check("t2_occ_after", 32'(oc0), 32'h3);
`endif
    repeat (4) step();

    // 3: bubble collapse behind a stalled last stage
    or0 = 0; iv0 = 1; id0 = 8'h11;
    step(); iv0 = 0;
    step(); step();
    check("t3_s2_only", 32'(od0), 32'h11);
    iv0 = 1; id0 = 8'h12; #1;
    check("t3_acc1", 32'(ir0), 32'h1);
    step(); id0 = 8'h13;
    check("t3_acc2", 32'(ir0), 32'h1);
    step(); id0 = 8'h14;
    check("t3_full", 32'(ir0), 32'h0);
`ifdef PIPE_OCC_EN
    check("t3_occ3", 32'(oc0), 32'h3);
`endif
    iv0 = 0; or0 = 1;
    repeat (4) step();

    // 4: flush a full chain with a pending input
    or0 = 0; iv0 = 1; id0 = 8'hA1;
    step(); id0 = 8'hA2;
    step(); id0 = 8'hA3;
    step(); id0 = 8'hA4; fl0 = 1; #1;
    check("t4_flush_out_valid", 32'(ov0), 32'h0);
    check("t4_flush_in_ready", 32'(ir0), 32'h0);
    step(); fl0 = 0; iv0 = 0; or0 = 1; #1;
    check("t4_after_valid", 32'(ov0), 32'h0);
    check("t4_stale_data", 32'(od0), 32'hA1);
`ifdef PIPE_OCC_EN
    check("t4_occ0", 32'(oc0), 32'h0);
`endif
    repeat (3) step();
    check("t4_input_dropped", 32'(ov0), 32'h0);

    // 5: asynchronous reset mid-stream
    or0 = 1; iv0 = 1; id0 = 8'h21;
    step(); id0 = 8'h22;
    step(); id0 = 8'h23;
    step(); id0 = 8'h24;
    #3 rst_i = 1'b0;
    #1;
    check("t5_rst_out_valid", 32'(ov0), 32'h0);
    check("t5_rst_out_data", 32'(od0), 32'h0);
    check("t5_rst_in_ready", 32'(ir0), 32'h1);
    iv0 = 0;
    @(negedge clk_i);
    #2 rst_i = 1'b1;

    for (int n = 0; n < 12000 && !rand_done; n++) @(posedge clk_i);
    if (!rand_done) check("random_timeout", 32'h0, 32'h1);
    repeat (8) step();
    check("final_d1_empty", 32'(ov1), 32'h0);
    check("final_d4_empty", 32'(ov2), 32'h0);
    check("final_d1_sb", 32'(sb_wr[1] - sb_rd[1]), 32'h0);
    check("final_d4_sb", 32'(sb_wr[2] - sb_rd[2]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
